// File: rtl/run_sequencer.sv
// Program-slot run sequencer: loads a slot base address, steps the fetch
// address with stall/halt/branch control, and faults on timeout or slot escape.
module run_sequencer #(
    parameter int D       = 8,
    parameter int NP      = 4,
    parameter int TW      = 16,
    parameter int MAX_CYC = 1000,
    localparam int SW     = $clog2(NP)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [SW-1:0] prog_sel,
    input  logic          branch,
    input  logic [D-1:0]  target,
    input  logic          halt,
    input  logic          stall,
    output logic [D-1:0]  prog_ctr,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic [TW-1:0] cyc_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [D-1:0]  SEG_MASK = D'((2 ** (D - SW)) - 1);
    localparam logic [TW-1:0] CYC_LAST = TW'(MAX_CYC - 1);

    logic [2:0]    state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [TW-1:0] cyc_q, cyc_d;
    logic [SW-1:0] slot_q, slot_d;

    logic [D:0] br_sum;
    logic       br_out;
    logic       seg_end;
    logic       halting;

    // Branch sum carries one extra bit so both underflow and overflow land
    // with the top bit set and are caught as leaving the slot.
    assign br_sum  = {1'b0, pc_q} + {target[D-1], target};
    assign br_out  = br_sum[D] || (br_sum[D-1 -: SW] != slot_q);
    assign seg_end = (pc_q & SEG_MASK) == SEG_MASK;
    assign halting = halt && !stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cyc_d   = cyc_q;
        slot_d  = slot_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    slot_d  = prog_sel;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pc_d    = D'(slot_q) << (D - SW);
                cyc_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // The count advances only while the run continues, so on exit
                // it holds the index of the final RUN cycle.
                if (cyc_q == CYC_LAST && !halting) begin
                    state_d = S_FAULT;
                end else if (stall) begin
                    cyc_d = cyc_q + TW'(1);
                end else if (halt) begin
                    state_d = S_DONE;
                end else if (branch) begin
                    if (br_out) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d  = br_sum[D-1:0];
                        cyc_d = cyc_q + TW'(1);
                    end
                end else if (seg_end) begin
                    state_d = S_DONE;
                end else begin
                    pc_d  = pc_q + D'(1);
                    cyc_d = cyc_q + TW'(1);
                end
            end
            S_DONE, S_FAULT: begin
                if (!req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cyc_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cyc_q   <= cyc_d;
            slot_q  <= slot_d;
        end
    end

    assign prog_ctr = pc_q;
    assign cyc_cnt  = cyc_q;
    assign busy     = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done     = (state_q == S_DONE) || (state_q == S_FAULT);
    assign fault    = (state_q == S_FAULT);

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: a short-timeout instance and a long-timeout
// instance share stimulus; each scenario task checks hand-computed values.
module tb_run_sequencer;

    logic       clk = 1'b0;
    logic       reset, req, branch, halt, stall;
    logic [1:0] prog_sel;
    logic [7:0] target;

    logic [7:0]  prog_ctr, prog_ctr_l;
    logic        busy, done, fault, busy_l, done_l, fault_l;
    logic [15:0] cyc_cnt, cyc_cnt_l;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    run_sequencer #(.D(8), .NP(4), .TW(16), .MAX_CYC(20)) dut (
        .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel),
        .branch(branch), .target(target), .halt(halt), .stall(stall),
        .prog_ctr(prog_ctr), .busy(busy), .done(done), .fault(fault),
        .cyc_cnt(cyc_cnt)
    );

    run_sequencer #(.D(8), .NP(4), .TW(16), .MAX_CYC(100)) dut_long (
        .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel),
        .branch(branch), .target(target), .halt(halt), .stall(stall),
        .prog_ctr(prog_ctr_l), .busy(busy_l), .done(done_l), .fault(fault_l),
        .cyc_cnt(cyc_cnt_l)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 1'b0; branch = 1'b0; halt = 1'b0; stall = 1'b0;
        target = 8'd0; prog_sel = 2'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Leaves both instances in RUN at the slot base with req held high.
    task automatic start(input logic [1:0] sel);
        req = 1'b1;
        prog_sel = sel;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (prog_ctr !== 8'd0) begin n_bad++; $display("FAIL reset_pc: got %0d want 0", prog_ctr); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", fault); end
        n_cmp++; if (cyc_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cyc: got %0d want 0", cyc_cnt); end
    endtask

    task automatic test_load();
        do_reset();
        req = 1'b1; prog_sel = 2'd2;
        step();
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL load_state: got busy=%b done=%b want busy=1 done=0", busy, done); end
        prog_sel = 2'd3;
        step();
        n_cmp++; if (prog_ctr !== 8'd128) begin n_bad++; $display("FAIL load_pc: got %0d want 128", prog_ctr); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL load_busy: got %b want 1", busy); end
        n_cmp++; if (cyc_cnt !== 16'd0) begin n_bad++; $display("FAIL load_cyc: got %0d want 0", cyc_cnt); end
        step();
        n_cmp++; if (prog_ctr !== 8'd129 || cyc_cnt !== 16'd1) begin n_bad++; $display("FAIL run_first_step: got pc=%0d cyc=%0d want pc=129 cyc=1", prog_ctr, cyc_cnt); end
    endtask

    task automatic test_seq_run();
        int pc_errs;
        do_reset();
        start(2'd0);
        pc_errs = 0;
        for (int i = 0; i < 64; i++) begin
            if (prog_ctr_l !== 8'(i) || busy_l !== 1'b1) pc_errs++;
            step();
        end
        n_cmp++; if (pc_errs != 0) begin n_bad++; $display("FAIL seq_walk: got %0d bad cycles want 0", pc_errs); end
        n_cmp++; if (done_l !== 1'b1 || busy_l !== 1'b0 || fault_l !== 1'b0) begin n_bad++; $display("FAIL seq_end_state: got done=%b busy=%b fault=%b want 1 0 0", done_l, busy_l, fault_l); end
        n_cmp++; if (prog_ctr_l !== 8'd63) begin n_bad++; $display("FAIL seq_end_pc: got %0d want 63", prog_ctr_l); end
        req = 1'b0;
        step();
        n_cmp++; if (done_l !== 1'b0 || busy_l !== 1'b0) begin n_bad++; $display("FAIL seq_to_idle: got done=%b busy=%b want 0 0", done_l, busy_l); end
    endtask

    task automatic test_branch();
        do_reset();
        start(2'd0);
        req = 1'b0;
        repeat (10) step();
        n_cmp++; if (prog_ctr !== 8'd10 || busy !== 1'b1) begin n_bad++; $display("FAIL req_drop_run: got pc=%0d busy=%b want pc=10 busy=1", prog_ctr, busy); end
        branch = 1'b1; target = 8'hFD;
        step();
        branch = 1'b0;
        n_cmp++; if (prog_ctr !== 8'd7 || busy !== 1'b1) begin n_bad++; $display("FAIL branch_back: got pc=%0d busy=%b want pc=7 busy=1", prog_ctr, busy); end

        do_reset();
        start(2'd0);
        repeat (10) step();
        branch = 1'b1; halt = 1'b1; target = 8'hFD;
        step();
        branch = 1'b0; halt = 1'b0;
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || fault !== 1'b0) begin n_bad++; $display("FAIL halt_state: got done=%b busy=%b fault=%b want 1 0 0", done, busy, fault); end
        n_cmp++; if (prog_ctr !== 8'd10) begin n_bad++; $display("FAIL halt_pc: got %0d want 10", prog_ctr); end
        step();
        n_cmp++; if (done !== 1'b1 || prog_ctr !== 8'd10) begin n_bad++; $display("FAIL done_hold: got done=%b pc=%0d want done=1 pc=10", done, prog_ctr); end
        req = 1'b0;
        step();
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL done_to_idle: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_branch_fault();
        do_reset();
        start(2'd0);
        branch = 1'b1; target = 8'd60;
        step();
        n_cmp++; if (prog_ctr !== 8'd60 || busy !== 1'b1) begin n_bad++; $display("FAIL branch_fwd: got pc=%0d busy=%b want pc=60 busy=1", prog_ctr, busy); end
        target = 8'd10;
        step();
        branch = 1'b0;
        n_cmp++; if (fault !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL escape_hi_state: got fault=%b done=%b busy=%b want 1 1 0", fault, done, busy); end
        n_cmp++; if (prog_ctr !== 8'd60) begin n_bad++; $display("FAIL escape_hi_pc: got %0d want 60", prog_ctr); end

        do_reset();
        start(2'd1);
        branch = 1'b1; target = 8'hFF;
        step();
        branch = 1'b0;
        n_cmp++; if (fault !== 1'b1 || prog_ctr !== 8'd64) begin n_bad++; $display("FAIL escape_lo: got fault=%b pc=%0d want fault=1 pc=64", fault, prog_ctr); end
    endtask

    task automatic test_timeout();
        do_reset();
        stall = 1'b1;
        start(2'd1);
        repeat (19) step();
        n_cmp++; if (busy !== 1'b1 || prog_ctr !== 8'd64 || cyc_cnt !== 16'd19) begin n_bad++; $display("FAIL stall_run: got busy=%b pc=%0d cyc=%0d want busy=1 pc=64 cyc=19", busy, prog_ctr, cyc_cnt); end
        step();
        n_cmp++; if (fault !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL timeout_state: got fault=%b done=%b busy=%b want 1 1 0", fault, done, busy); end
        n_cmp++; if (prog_ctr !== 8'd64 || cyc_cnt !== 16'd19) begin n_bad++; $display("FAIL timeout_vals: got pc=%0d cyc=%0d want pc=64 cyc=19", prog_ctr, cyc_cnt); end
        step();
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL fault_hold: got %b want 1", fault); end
        req = 1'b0; stall = 1'b0;
        step();
        n_cmp++; if (fault !== 1'b0 || done !== 1'b0 || cyc_cnt !== 16'd19) begin n_bad++; $display("FAIL idle_retain: got fault=%b done=%b cyc=%0d want 0 0 19", fault, done, cyc_cnt); end
    endtask

    task automatic test_stall_priority();
        do_reset();
        start(2'd0);
        repeat (3) step();
        stall = 1'b1; halt = 1'b1; branch = 1'b1; target = 8'd5;
        step();
        n_cmp++; if (prog_ctr !== 8'd3 || busy !== 1'b1 || cyc_cnt !== 16'd4) begin n_bad++; $display("FAIL stall_prio: got pc=%0d busy=%b cyc=%0d want pc=3 busy=1 cyc=4", prog_ctr, busy, cyc_cnt); end
        stall = 1'b0; halt = 1'b0; branch = 1'b0;
        step();
        n_cmp++; if (prog_ctr !== 8'd4) begin n_bad++; $display("FAIL stall_release: got %0d want 4", prog_ctr); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        start(2'd0);
        branch = 1'b1; target = 8'd30;
        step();
        branch = 1'b0;
        n_cmp++; if (prog_ctr !== 8'd30) begin n_bad++; $display("FAIL pre_reset_pc: got %0d want 30", prog_ctr); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (prog_ctr !== 8'd0 || busy !== 1'b0 || cyc_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_reset: got pc=%0d busy=%b cyc=%0d want 0 0 0", prog_ctr, busy, cyc_cnt); end
        step();
        n_cmp++; if (busy !== 1'b1 || prog_ctr !== 8'd0) begin n_bad++; $display("FAIL reload: got busy=%b pc=%0d want busy=1 pc=0", busy, prog_ctr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_seq_run();
        test_branch();
        test_branch_fault();
        test_timeout();
        test_stall_priority();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameter D, default 8, program counter width in bits.
REQ-002 SHALL have parameter NP, default 4, number of program slots; power of two, at least 2, at most 2^D.
REQ-003 SHALL have parameter TW, default 16, cycle counter width in bits.
REQ-004 SHALL have parameter MAX_CYC, default 1000, RUN-cycle limit before fault; at least 2 and at most 2^TW-1.
REQ-005 SHALL derive SW = clog2(NP) and SEG = 2^D/NP; slot k spans addresses k*SEG to k*SEG+SEG-1.
REQ-006 SHALL have port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, synchronous and active-high.
REQ-008 SHALL have port req, input, 1 bit, run request (level, 4-phase handshake).
REQ-009 SHALL have port prog_sel, input, SW bits, program slot; sampled in IDLE only.
REQ-010 SHALL have port branch, input, 1 bit, relative jump enable from control.
REQ-011 SHALL have port target, input, D bits, signed two's-complement jump offset.
REQ-012 SHALL have port halt, input, 1 bit, decoded halt instruction.
REQ-013 SHALL have port stall, input, 1 bit, freezes prog_ctr.
REQ-014 SHALL have port prog_ctr, output, D bits, fetch address, registered.
REQ-015 SHALL have port busy, output, 1 bit, high in LOAD and RUN.
REQ-016 SHALL have port done, output, 1 bit, high in DONE and FAULT.
REQ-017 SHALL have port fault, output, 1 bit, high in FAULT only.
REQ-018 SHALL have port cyc_cnt, output, TW bits, RUN cycles of the current or last run.

Function
REQ-019 SHALL implement states IDLE, LOAD, RUN, DONE, FAULT; busy, done and fault are decoded from state.
REQ-020 IDLE: req=1 -> LOAD, latching prog_sel into slot register; req=0 -> stay.
REQ-021 LOAD (exactly 1 cycle): prog_ctr <= slot*SEG; cyc_cnt <= 0; -> RUN.
REQ-022 RUN: cyc_cnt increments by 1 each RUN cycle, stalled or not.
REQ-023 RUN priority, highest first: timeout, stall, halt, branch, sequential.
REQ-024 Timeout: cyc_cnt == MAX_CYC-1 with the current cycle not halting -> FAULT, prog_ctr held.
REQ-025 stall=1: prog_ctr held; halt and branch ignored that cycle.
REQ-026 halt=1: -> DONE; prog_ctr held; a simultaneous branch is ignored.
REQ-027 branch=1: next = prog_ctr + sign-extended target, computed at D+1 bits.
REQ-028 Branch result outside the current slot span (including arithmetic wrap) -> FAULT; prog_ctr held.
REQ-029 Sequential step from slot*SEG+SEG-1 -> DONE; prog_ctr held (end-of-program).
REQ-030 Otherwise prog_ctr <= prog_ctr + 1.
REQ-031 DONE/FAULT: outputs held; req=0 -> IDLE; req=1 -> stay (no auto-restart).
REQ-032 cyc_cnt SHALL retain its final value through DONE, FAULT and IDLE until the next LOAD.
REQ-033 prog_sel changes outside IDLE SHALL have no effect.
REQ-034 req dropping during LOAD or RUN SHALL not abort the run.

Reset
REQ-035 reset=1 at a rising edge SHALL force IDLE from any state, including mid-RUN.
REQ-036 Reset SHALL set prog_ctr=0, cyc_cnt=0, slot=0, busy=0, done=0, fault=0, effective the following cycle.
REQ-037 Reset SHALL take priority over every other input.

Verification (D=8, NP=4, SEG=64, MAX_CYC=20)
REQ-038 Reset, req=1, prog_sel=2 -> LOAD 1 cycle, then prog_ctr=128, busy=1, cyc_cnt=0.
REQ-039 prog_sel=0, no branch/halt, MAX_CYC=100 -> prog_ctr 0..63, then done=1, prog_ctr=63; req=0 -> IDLE next cycle.
REQ-040 branch=1, target=8'hFD at prog_ctr=10 -> prog_ctr=7; same cycle with halt=1 -> DONE, prog_ctr=10.
REQ-041 slot 0, branch target=+10 at prog_ctr=60 -> FAULT, fault=1, done=1, prog_ctr=60.
REQ-042 stall held from LOAD -> prog_ctr frozen, FAULT after 20 RUN cycles, cyc_cnt=19.
REQ-043 reset=1 at prog_ctr=30 in RUN -> next cycle IDLE, prog_ctr=0, busy=0; req still high -> LOAD following cycle.
